// File: rtl/prog_loader.sv
// Program loader: receives a byte stream from the host link, packs pairs of
// bytes into 14-bit program words, writes them to program memory and checks a
// trailing 8-bit checksum. The CPU is held in reset while a load is running
// and after a failed load.
module prog_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [12:0] word_count,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [12:0] mem_addr,
    output logic [13:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int DATA_W = 8;
    localparam int ADDR_W = 13;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t              state;
    state_t              state_nx;

    logic [ADDR_W-1:0]   count;     // captured word_count
    logic [ADDR_W-1:0]   addr;      // address of the word being assembled
    logic [DATA_W-1:0]   sum;       // running byte sum, wraps modulo 256
    logic [5:0]          hi;        // word bits [13:8]
    logic [DATA_W-1:0]   lo;        // word bits [7:0]

    logic                xfer;
    logic                idle_like;
    logic                accept;
    logic                hi_legal;
    logic                last_word;
    logic [DATA_W-1:0]   sum_chk;

    // Running sum is plain 8-bit addition; overflow wraps by design.
    function automatic logic [DATA_W-1:0] sum_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    assign xfer      = byte_valid && byte_ready;
    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign accept    = idle_like && start;
    assign hi_legal  = (byte_in[7:6] == 2'b00);
    // Only evaluated in WRITE, where count is at least 1.
    assign last_word = (addr == (count - 13'd1));
    assign sum_chk   = sum_wrap(sum, byte_in);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nx = (word_count == '0) ? S_CHK : S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    state_nx = hi_legal ? S_LO : S_ERR;
                end
            end
            S_LO: begin
                if (xfer) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nx = last_word ? S_CHK : S_HI;
            end
            S_CHK: begin
                if (xfer) begin
                    state_nx = (sum_chk == '0) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state; memory bus is zero outside WRITE.
    always_comb begin
        byte_ready = (state == S_HI) || (state == S_LO) || (state == S_CHK);
        mem_we     = (state == S_WRITE);
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state == S_WRITE) begin
            mem_addr  = addr;
            mem_wdata = {hi, lo};
        end
        busy     = (state == S_HI) || (state == S_LO) ||
                   (state == S_WRITE) || (state == S_CHK);
        cpu_hold = busy || (state == S_ERR);
        done     = (state == S_DONE);
        error    = (state == S_ERR);
    end

    // Word assembly, address counter and running checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            addr  <= '0;
            sum   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (accept) begin
                count <= word_count;
                addr  <= '0;
                sum   <= '0;
            end else begin
                case (state)
                    S_HI: begin
                        if (xfer && hi_legal) begin
                            hi  <= byte_in[5:0];
                            sum <= sum_chk;
                        end
                    end
                    S_LO: begin
                        if (xfer) begin
                            lo  <= byte_in;
                            sum <= sum_chk;
                        end
                    end
                    S_WRITE: begin
                        // Stay on the last address so the counter never
                        // passes word_count-1.
                        if (!last_word) begin
                            addr <= addr + 13'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
